// File: rtl/spi_ram_master_if.sv
// Host request/response bus plus SPI pins of the SPI RAM master.
//   req_*      : host request (valid/ready handshake, op, address, write data)
//   rsp_*      : one-cycle completion pulse with read data
//   busy       : transaction in flight
//   SS_n/MOSI  : slave select and serial data towards the SPI slave
//   MISO       : serial data from the SPI slave
// Modport master is the SPI master itself; modport slave is the host/pin side.
interface spi_ram_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, MISO,
        output req_ready, rsp_valid, rsp_rdata, busy, SS_n, MOSI
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, MISO,
        input  req_ready, rsp_valid, rsp_rdata, busy, SS_n, MOSI
    );
endinterface

// File: rtl/spi_ram_master.sv
// Host-side SPI master for the SPI slave + RAM wrapper.
// Turns one host write/read request into address/data frames, captures read-back data
// and caches the slave's latched write/read addresses to skip redundant address frames.
//   clk  : system clock, also the serial bit clock
//   rst  : asynchronous active-high reset
//   bus  : spi_ram_master_if.master (request/response handshake, SS_n, MOSI, MISO)
// Frame: SEL cycle (MOSI=0), then 11 bits {sel, cmd[1:0], d[7:0]} MSB first, optional
// WAIT + 8-cycle CAPT for read-data frames, one END cycle, then GAP_CYC cycles SS_n high.
module spi_ram_master #(
    parameter int unsigned RD_LAT     = 2,    // 1..7
    parameter int unsigned GAP_CYC    = 1,    // >= 1
    parameter bit          ADDR_CACHE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    spi_ram_master_if.master bus
);

    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StShift,
        StWait,
        StCapt,
        StEnd,
        StGap
    } state_e;

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [GapW-1:0]   r_gap_cnt, w_gap_cnt_nxt;

    logic              r_op;
    logic [7:0]        r_addr;
    logic [7:0]        r_wdata;
    logic              r_addr_phase;   // current frame is the address frame
    logic              r_wr_vld, r_rd_vld;
    logic [7:0]        r_wr_addr, r_rd_addr;
    logic [7:0]        r_rdata;
    logic              r_ss_n;
    logic              r_mosi;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_cache_hit;
    logic              w_rd_data_frame;
    logic              w_last_gap;
    logic [10:0]       w_frame;
    logic              w_ss_n_nxt;
    logic              w_mosi_nxt;

    assign w_req_ready     = (r_state == StIdle) && !rst;
    assign w_accept        = bus.req_valid && w_req_ready;
    assign w_rd_data_frame = r_op && !r_addr_phase;
    assign w_last_gap      = (r_state == StGap) && (r_gap_cnt == '0);

    assign w_cache_hit = ADDR_CACHE &&
        (bus.req_op ? (r_rd_vld && (r_rd_addr == bus.req_addr))
                    : (r_wr_vld && (r_wr_addr == bus.req_addr)));

    // sel = op, cmd = {op, data-frame}; read-data frames carry a dummy byte.
    assign w_frame = {r_op, r_op, !r_addr_phase,
                      r_addr_phase ? r_addr : (r_op ? 8'h00 : r_wdata)};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            StIdle: begin
                if (w_accept) w_state_nxt = StSel;
            end
            StSel: begin
                w_state_nxt   = StShift;
                w_bit_cnt_nxt = 4'd10;
            end
            StShift: begin
                if (r_bit_cnt == 4'd0) begin
                    if (!w_rd_data_frame) begin
                        w_state_nxt = StEnd;
                    end else if (RD_LAT == 1) begin
                        w_state_nxt   = StCapt;
                        w_bit_cnt_nxt = 4'd7;
                    end else begin
                        w_state_nxt   = StWait;
                        w_bit_cnt_nxt = 4'(RD_LAT - 2);
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - 4'd1;
                end
            end
            StWait: begin
                if (r_bit_cnt == 4'd0) begin
                    w_state_nxt   = StCapt;
                    w_bit_cnt_nxt = 4'd7;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - 4'd1;
                end
            end
            StCapt: begin
                if (r_bit_cnt == 4'd0) w_state_nxt = StEnd;
                else                   w_bit_cnt_nxt = r_bit_cnt - 4'd1;
            end
            StEnd: begin
                w_state_nxt   = StGap;
                w_gap_cnt_nxt = GapW'(GAP_CYC - 1);
            end
            StGap: begin
                if (r_gap_cnt == '0) w_state_nxt = r_addr_phase ? StSel : StIdle;
                else                 w_gap_cnt_nxt = r_gap_cnt - GapW'(1);
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Output logic; SS_n/MOSI are computed for the next state and then registered.
    always_comb begin
        w_ss_n_nxt = (w_state_nxt == StIdle) || (w_state_nxt == StGap);
        w_mosi_nxt = 1'b0;
        if (w_state_nxt == StShift) w_mosi_nxt = w_frame[w_bit_cnt_nxt];
    end

    assign bus.req_ready = w_req_ready;
    assign bus.busy      = (r_state != StIdle);
    assign bus.rsp_valid = w_last_gap && !r_addr_phase;
    assign bus.rsp_rdata = r_rdata;
    assign bus.SS_n      = r_ss_n;
    assign bus.MOSI      = r_mosi;

    // Request latch, address caches, read capture and registered pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_addr_phase <= 1'b0;
            r_wr_vld     <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_rdata      <= '0;
            r_ss_n       <= 1'b1;
            r_mosi       <= 1'b0;
        end else begin
            r_ss_n <= w_ss_n_nxt;
            r_mosi <= w_mosi_nxt;
            if (w_accept) begin
                r_op         <= bus.req_op;
                r_addr       <= bus.req_addr;
                r_wdata      <= bus.req_wdata;
                r_addr_phase <= !w_cache_hit;
                if (!bus.req_op) r_rdata <= '0;
            end
            if (r_state == StCapt) r_rdata <= {r_rdata[6:0], bus.MISO};
            // The slave has latched the address once the address frame ends.
            if ((r_state == StEnd) && r_addr_phase) begin
                if (r_op) begin
                    r_rd_vld  <= 1'b1;
                    r_rd_addr <= r_addr;
                end else begin
                    r_wr_vld  <= 1'b1;
                    r_wr_addr <= r_addr;
                end
            end
            if (w_last_gap) r_addr_phase <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: dut0 uses default parameters and is checked every cycle against
// a frame-level waveform model; dut1 (ADDR_CACHE=0, RD_LAT=1) gets directed checks.
module tb_spi_ram_master;

    localparam int M_RD_LAT = 2;
    localparam int M_GAP    = 1;

    typedef struct packed {
        logic       ss;
        logic       mosi;
        logic       rv;
        logic [7:0] rd;
    } rec_t;

    logic clk;
    logic rst;

    logic       rv     [2];
    logic       rop    [2];
    logic [7:0] raddr  [2];
    logic [7:0] rwd    [2];
    logic       miso_v [2];

    logic       w_ready [2];
    logic       w_rspv  [2];
    logic [7:0] w_rdata [2];
    logic       w_busy  [2];
    logic       w_ss    [2];
    logic       w_mosi  [2];

    logic [7:0] slave_byte [2];
    logic [11:0] flog [$];   // {instance, 11-bit frame}
    rec_t        exp_q [$];
    logic        m_wr_v, m_rd_v;
    logic [7:0]  m_wr_a, m_rd_a;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lat;
    logic [7:0] rd;

    spi_ram_master_if u_if0 ();
    spi_ram_master_if u_if1 ();

    assign u_if0.req_valid = rv[0];
    assign u_if0.req_op    = rop[0];
    assign u_if0.req_addr  = raddr[0];
    assign u_if0.req_wdata = rwd[0];
    assign u_if0.MISO      = miso_v[0];
    assign u_if1.req_valid = rv[1];
    assign u_if1.req_op    = rop[1];
    assign u_if1.req_addr  = raddr[1];
    assign u_if1.req_wdata = rwd[1];
    assign u_if1.MISO      = miso_v[1];

    assign w_ready[0] = u_if0.req_ready;
    assign w_rspv[0]  = u_if0.rsp_valid;
    assign w_rdata[0] = u_if0.rsp_rdata;
    assign w_busy[0]  = u_if0.busy;
    assign w_ss[0]    = u_if0.SS_n;
    assign w_mosi[0]  = u_if0.MOSI;
    assign w_ready[1] = u_if1.req_ready;
    assign w_rspv[1]  = u_if1.rsp_valid;
    assign w_rdata[1] = u_if1.rsp_rdata;
    assign w_busy[1]  = u_if1.busy;
    assign w_ss[1]    = u_if1.SS_n;
    assign w_mosi[1]  = u_if1.MOSI;

    spi_ram_master #(.RD_LAT(2), .GAP_CYC(1), .ADDR_CACHE(1'b1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (u_if0.master)
    );

    spi_ram_master #(.RD_LAT(1), .GAP_CYC(1), .ADDR_CACHE(1'b0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (u_if1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- waveform model for dut0 ----------------
    function automatic void push_frame(input logic [10:0] w, input bit rd_frame,
                                       input bit last, input logic [7:0] rdv);
        exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00});                 // select cycle
        for (int i = 10; i >= 0; i--) exp_q.push_back({1'b0, w[i], 1'b0, 8'h00});
        if (rd_frame)
            for (int i = 0; i < M_RD_LAT - 1 + 8; i++) exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00});
        exp_q.push_back({1'b0, 1'b0, 1'b0, 8'h00});                 // end cycle
        for (int g = 0; g < M_GAP; g++)
            exp_q.push_back({1'b1, 1'b0, (last && g == M_GAP - 1), rdv});
    endfunction

    function automatic void model_accept(input logic op, input logic [7:0] a,
                                         input logic [7:0] d);
        bit hit;
        hit = op ? (m_rd_v && m_rd_a == a) : (m_wr_v && m_wr_a == a);
        if (!hit) begin
            push_frame({op, op, 1'b0, a}, 1'b0, 1'b0, 8'h00);
            if (op) begin
                m_rd_v = 1'b1;
                m_rd_a = a;
            end else begin
                m_wr_v = 1'b1;
                m_wr_a = a;
            end
        end
        if (op) push_frame({3'b111, 8'h00}, 1'b1, 1'b1, slave_byte[0]);
        else    push_frame({3'b001, d}, 1'b0, 1'b1, 8'h00);
    endfunction

    // Single compare process for dut0.
    initial begin
        rec_t r;
        m_wr_v = 1'b0;
        m_rd_v = 1'b0;
        m_wr_a = '0;
        m_rd_a = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset SS_n", w_ss[0], 1);
                chk("reset MOSI", w_mosi[0], 0);
                chk("reset req_ready", w_ready[0], 0);
                chk("reset busy", w_busy[0], 0);
                chk("reset rsp_valid", w_rspv[0], 0);
                chk("reset rsp_rdata", w_rdata[0], 0);
                exp_q.delete();
                m_wr_v = 1'b0;
                m_rd_v = 1'b0;
            end else if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("SS_n", w_ss[0], r.ss);
                chk("MOSI", w_mosi[0], r.mosi);
                chk("busy", w_busy[0], 1);
                chk("req_ready busy", w_ready[0], 0);
                chk("rsp_valid", w_rspv[0], r.rv);
                if (r.rv) chk("rsp_rdata", w_rdata[0], r.rd);
            end else begin
                chk("idle SS_n", w_ss[0], 1);
                chk("idle MOSI", w_mosi[0], 0);
                chk("idle busy", w_busy[0], 0);
                chk("idle rsp_valid", w_rspv[0], 0);
                chk("idle req_ready", w_ready[0], 1);
                if (rv[0]) model_accept(rop[0], raddr[0], rwd[0]);
            end
        end
    end

    // ---------------- SPI slave model for both DUTs ----------------
    initial begin
        int pos [2];
        int start [2];
        logic [10:0] word [2];
        int j;
        for (int i = 0; i < 2; i++) begin
            pos[i]    = 0;
            start[i]  = -100;
            word[i]   = '0;
            miso_v[i] = 1'b1;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (w_ss[i] == 1'b0) begin
                    if (pos[i] >= 1 && pos[i] <= 11) word[i] = {word[i][9:0], w_mosi[i]};
                    if (pos[i] == 11) begin
                        flog.push_back({i[0], word[i]});
                        if (word[i] == 11'h700) start[i] = cyc + ((i == 0) ? 2 : 1);
                    end
                    pos[i] = pos[i] + 1;
                end else begin
                    pos[i] = 0;
                end
                if (cyc >= start[i] && cyc < start[i] + 8) begin
                    j = 7 - (cyc - start[i]);
                    miso_v[i] = slave_byte[i][j];
                end else begin
                    miso_v[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input int i, input logic op, input logic [7:0] a, input logic [7:0] d,
                          output int l, output logic [7:0] rdv);
        int acc;
        bit got;
        acc = 0;
        l   = -1;
        rdv = 8'h00;
        @(posedge clk);
        #1;
        rv[i]    = 1'b1;
        rop[i]   = op;
        raddr[i] = a;
        rwd[i]   = d;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (w_ready[i]) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        @(posedge clk);
        #1;
        rv[i] = 1'b0;
        chk("accept seen", got, 1);
        if (got) begin
            got = 1'b0;
            for (int n = 0; n < 200 && !got; n++) begin
                @(negedge clk);
                if (w_rspv[i]) begin
                    got = 1'b1;
                    l   = cyc - acc;
                    rdv = w_rdata[i];
                end
            end
            chk("rsp seen", got, 1);
        end
    endtask

    task automatic expect_frames(input string nm, input int n, input logic [11:0] e0,
                                 input logic [11:0] e1);
        chk({nm, " frame count"}, flog.size(), n);
        if (flog.size() >= 1) chk({nm, " frame 0"}, flog[0], e0);
        if (n == 2 && flog.size() >= 2) chk({nm, " frame 1"}, flog[1], e1);
    endtask

    task automatic reset_mid_write();
        bit got;
        @(posedge clk);
        #1;
        rv[0] = 1'b1; rop[0] = 1'b0; raddr[0] = 8'h20; rwd[0] = 8'h99;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (w_ready[0]) got = 1'b1;
        end
        chk("abort accept seen", got, 1);
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        // Bit counter is at 5 here: address bit 5 of 0x20 is on MOSI.
        chk("frame active before reset", w_ss[0], 0);
        chk("addr bit5 before reset", w_mosi[0], 1);
        rst = 1'b1;
        #1;
        chk("SS_n at reset", w_ss[0], 1);
        chk("MOSI at reset", w_mosi[0], 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("aborted frame incomplete", flog.size(), 0);
    endtask

    initial begin
        int a1, r1, a2;
        bit got;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rop[i] = 1'b0; raddr[i] = '0; rwd[i] = '0; slave_byte[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill the write cache, then abort the next address frame with reset.
        flog.delete();
        do_req(0, 1'b0, 8'h3C, 8'h3C, lat, rd);
        chk("wr 3C latency", lat, 28);
        flog.delete();
        reset_mid_write();
        flog.delete();
        do_req(0, 1'b0, 8'h3C, 8'h3C, lat, rd);
        chk("wr 3C after reset latency", lat, 28);
        expect_frames("wr 3C after reset", 2, 12'h03C, 12'h13C);

        flog.delete();
        do_req(0, 1'b0, 8'hFF, 8'hFF, lat, rd);
        chk("wr FF latency", lat, 28);
        chk("wr FF rdata", rd, 0);
        expect_frames("wr FF/FF", 2, 12'h0FF, 12'h1FF);

        flog.delete();
        do_req(0, 1'b0, 8'hFF, 8'h5A, lat, rd);
        chk("wr hit latency", lat, 14);
        expect_frames("wr hit", 1, 12'h15A, 12'h000);

        slave_byte[0] = 8'h5A;
        flog.delete();
        do_req(0, 1'b1, 8'hFF, 8'h00, lat, rd);
        chk("rd FF latency", lat, 37);
        chk("rd FF data", rd, 8'h5A);
        expect_frames("rd FF", 2, 12'h6FF, 12'h700);

        slave_byte[0] = 8'hA5;
        do_req(0, 1'b1, 8'hFF, 8'h00, lat, rd);
        chk("rd hit latency", lat, 23);
        chk("rd hit data", rd, 8'hA5);

        do_req(0, 1'b0, 8'hFF, 8'h00, lat, rd);
        chk("wr hit after rd latency", lat, 14);
        slave_byte[0] = 8'h00;
        do_req(0, 1'b1, 8'hFF, 8'h00, lat, rd);
        chk("rd hit after wr latency", lat, 23);
        chk("rd zero data", rd, 8'h00);

        // req_valid held high with a wandering address.
        @(posedge clk);
        #1;
        rv[0] = 1'b1; rop[0] = 1'b0; raddr[0] = 8'h77; rwd[0] = 8'h11;
        got = 1'b0; a1 = 0; r1 = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (w_ready[0]) begin
                got = 1'b1;
                a1  = cyc;
            end
        end
        chk("held accept 1", got, 1);
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(posedge clk);
            #1;
            raddr[0] = 8'($urandom);
            rwd[0]   = 8'($urandom);
            @(negedge clk);
            if (w_rspv[0]) begin
                got = 1'b1;
                r1  = cyc;
            end
        end
        chk("held rsp 1", got, 1);
        chk("held latency 1", r1 - a1, 28);
        @(posedge clk);
        #1;
        raddr[0] = 8'h77;
        rwd[0]   = 8'h22;
        @(negedge clk);
        chk("accept right after rsp", w_ready[0], 1);
        a2 = cyc;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (w_rspv[0]) begin
                got = 1'b1;
                chk("held latency 2", cyc - a2, 14);
            end
        end
        chk("held rsp 2", got, 1);

        // dut1: no address cache, read latency 1.
        slave_byte[1] = 8'hC3;
        flog.delete();
        do_req(1, 1'b1, 8'h10, 8'h00, lat, rd);
        chk("nc rd1 latency", lat, 36);
        chk("nc rd1 data", rd, 8'hC3);
        expect_frames("nc rd1", 2, 12'hE10, 12'hF00);
        slave_byte[1] = 8'h3C;
        flog.delete();
        do_req(1, 1'b1, 8'h10, 8'h00, lat, rd);
        chk("nc rd2 latency", lat, 36);
        chk("nc rd2 data", rd, 8'h3C);
        expect_frames("nc rd2", 2, 12'hE10, 12'hF00);

        repeat (5) @(posedge clk);
        #1;
        chk("dut1 idle", w_busy[1], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
